// File: rtl/mac_accumulator.sv
// ---------------------------------------------------------------------------
// mac_accumulator
//   Downstream consumer of the registered Wallace-tree multiplier. Sums a
//   START-framed run of LEN signed products into a wide signed accumulator
//   and presents the result on a valid/ready output port. o_pReady is only
//   high while a run is in progress, so the producer is held off while a
//   finished result waits to be taken.
//
//   Optional feature macro: SAT_EN
//     defined   -> on signed overflow the accumulator clamps to the most
//                  positive / most negative value (chosen by operand sign)
//     undefined -> the accumulator wraps modulo 2^ACC_WIDTH
//     In both builds o_ovf is set and stays set until the next run starts.
//
// Parameters
//   PROD_WIDTH  width of the signed product input
//   ACC_WIDTH   width of the accumulator and o_accOut (>= PROD_WIDTH)
//   LEN_WIDTH   width of i_len and of the remaining-products counter
//
// Ports
//   i_clk       clock, everything on the rising edge
//   i_reset     synchronous reset, active-low (0 = reset)
//   i_start     begin a run (honoured in IDLE, or in DONE with i_outReady)
//   i_len       number of products in the run, latched with i_start
//   i_pValid    i_p holds a valid product
//   i_p         signed product from the multiplier
//   o_pReady    block accepts i_p this cycle (state ACCUM)
//   o_accOut    signed accumulated result
//   o_outValid  o_accOut holds a completed result (state DONE)
//   i_outReady  consumer takes o_accOut
//   o_busy      run in progress (state ACCUM)
//   o_ovf       sticky signed-overflow flag for the current run
// ---------------------------------------------------------------------------
module mac_accumulator #(
  parameter int PROD_WIDTH = 64,
  parameter int ACC_WIDTH  = 80,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_pValid,
  input  logic [PROD_WIDTH-1:0] i_p,
  output logic                  o_pReady,
  output logic [ACC_WIDTH-1:0]  o_accOut,
  output logic                  o_outValid,
  input  logic                  i_outReady,
  output logic                  o_busy,
  output logic                  o_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [ACC_WIDTH-1:0]  r_accOut;
  logic                  r_ovf;
  logic [LEN_WIDTH-1:0]  r_remaining;

  logic                  w_accept;
  logic                  w_startRun;
  logic                  w_lastProduct;
  logic [ACC_WIDTH-1:0]  w_pExt;
  logic [ACC_WIDTH-1:0]  w_rawSum;
  logic                  w_addOvf;
  logic [ACC_WIDTH-1:0]  w_nextAcc;

  // A new run may begin from IDLE, or straight out of DONE in the same
  // cycle the consumer takes the previous result (no idle bubble).
  assign w_startRun    = i_start &&
                         ((r_state == IDLE) || ((r_state == DONE) && i_outReady));
  assign w_accept      = i_pValid && (r_state == ACCUM);
  assign w_lastProduct = (r_remaining == LEN_WIDTH'(1));

  // Signed overflow: both operands share a sign but the raw sum's sign differs.
  assign w_pExt   = ACC_WIDTH'($signed(i_p));
  assign w_rawSum = r_acc + w_pExt;
  assign w_addOvf = (r_acc[ACC_WIDTH-1] == w_pExt[ACC_WIDTH-1]) &&
                    (w_rawSum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

`ifdef SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // On overflow the shared operand sign tells which rail to clamp to.
  assign w_nextAcc = w_addOvf ? (r_acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : w_rawSum;
`else
  assign w_nextAcc = w_rawSum;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A zero-length run goes straight to DONE with a zero
  // result; otherwise the run ends on the accept that empties the counter.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = (i_len != '0) ? ACCUM : DONE;
        end
      end
      ACCUM: begin
        if (w_accept && w_lastProduct) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        if (i_outReady) begin
          if (i_start) begin
            w_nextState = (i_len != '0) ? ACCUM : DONE;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: clear on run start, fold in each accepted product, and
  // capture the final sum into the output register on the last accept so
  // o_accOut stays stable for the whole DONE period.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_acc       <= '0;
      r_accOut    <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= '0;
    end else if (w_startRun) begin
      r_acc       <= '0;
      r_accOut    <= '0;
      r_ovf       <= 1'b0;
      r_remaining <= i_len;
    end else if (w_accept) begin
      r_acc       <= w_nextAcc;
      r_remaining <= r_remaining - LEN_WIDTH'(1);
      if (w_addOvf) begin
        r_ovf <= 1'b1;
      end
      if (w_lastProduct) begin
        r_accOut <= w_nextAcc;
      end
    end
  end

  assign o_pReady   = (r_state == ACCUM);
  assign o_busy     = (r_state == ACCUM);
  assign o_outValid = (r_state == DONE);
  assign o_accOut   = r_accOut;
  assign o_ovf      = r_ovf;

endmodule
